// File: rtl/conv_result_streamer.sv
// Streams convolution results from the result memory as a valid/ready stream.
// Reads are prefetched into a 2-entry buffer so one beat can leave per cycle.
module conv_result_streamer #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [ADDR_WIDTH-1:0]   sizeX,
   input  logic [ADDR_WIDTH-1:0]   sizeY,
   output logic [ADDR_WIDTH:0]     memZ_addr,
   output logic                    memZ_rd,
   input  logic [2*DATA_WIDTH-1:0] memZ_data,
   output logic [2*DATA_WIDTH-1:0] m_data,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic                    m_last,
   output logic                    busy,
   output logic                    done,
   output logic [1:0]              dbg_state_o
);
   localparam int RW = 2*DATA_WIDTH;
   localparam int CW = ADDR_WIDTH+1;
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] FIN  = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] n_q, n_d;
   logic [CW-1:0] rd_cnt_q, rd_cnt_d;
   logic [CW-1:0] out_cnt_q, out_cnt_d;
   logic [CW-1:0] addr_q, addr_d;
   logic          inflight_q, inflight_d;
   logic [1:0]    cnt_q, cnt_d;
   logic [RW-1:0] buf0_q, buf0_d;
   logic [RW-1:0] buf1_q, buf1_d;
   logic [CW-1:0] n_start;
   logic [2:0]    occ;
   logic          pop, push, rd;

   // Stream handshake: a beat transfers when m_valid && m_ready; m_data/m_last hold while stalled.
   assign n_start = (sizeX == '0 || sizeY == '0) ? '0 :
                    {1'b0, sizeX} + {1'b0, sizeY} - CW'(1);
   assign m_valid = (state_q == RUN) && (cnt_q != 2'd0);
   assign m_last  = m_valid && (out_cnt_q == n_q - CW'(1));
   assign m_data  = buf0_q;
   assign pop     = m_valid && m_ready;
   assign push    = inflight_q;
   assign occ     = {1'b0, cnt_q} + {2'b0, inflight_q};
   // A read may issue only if its data is guaranteed a free buffer slot on arrival.
   assign rd      = (state_q == RUN) && (occ < 3'd2 + {2'b0, pop}) && (rd_cnt_q < n_q);

   assign memZ_rd     = rd;
   assign memZ_addr   = rd ? rd_cnt_q : addr_q;
   assign busy        = (state_q == RUN);
   assign done        = (state_q == FIN);
   assign dbg_state_o = state_q;

   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      rd_cnt_d   = rd_cnt_q;
      out_cnt_d  = out_cnt_q;
      addr_d     = addr_q;
      inflight_d = rd;
      cnt_d      = cnt_q;
      buf0_d     = buf0_q;
      buf1_d     = buf1_q;

      if (rd) begin
         rd_cnt_d = rd_cnt_q + CW'(1);
         addr_d   = rd_cnt_q;
      end
      if (pop) out_cnt_d = out_cnt_q + CW'(1);

      case ({push, pop})
         2'b10: begin
            if (cnt_q == 2'd0) buf0_d = memZ_data;
            else               buf1_d = memZ_data;
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            buf0_d = buf1_q;
            cnt_d  = cnt_q - 2'd1;
         end
         2'b11: begin
            if (cnt_q == 2'd1) begin
               buf0_d = memZ_data;
            end else begin
               buf0_d = buf1_q;
               buf1_d = memZ_data;
            end
         end
         default: ;
      endcase

      case (state_q)
         IDLE: begin
            if (start) begin
               n_d       = n_start;
               rd_cnt_d  = '0;
               out_cnt_d = '0;
               cnt_d     = 2'd0;
               state_d   = (n_start == '0) ? FIN : RUN;
            end
         end
         RUN:     if (pop && m_last) state_d = FIN;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         n_q        <= '0;
         rd_cnt_q   <= '0;
         out_cnt_q  <= '0;
         addr_q     <= '0;
         inflight_q <= 1'b0;
         cnt_q      <= 2'd0;
         buf0_q     <= '0;
         buf1_q     <= '0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         rd_cnt_q   <= rd_cnt_d;
         out_cnt_q  <= out_cnt_d;
         addr_q     <= addr_d;
         inflight_q <= inflight_d;
         cnt_q      <= cnt_d;
         buf0_q     <= buf0_d;
         buf1_q     <= buf1_d;
      end
   end
endmodule

// File: tb/tb_conv_result_streamer.sv
// Randomized bench for conv_result_streamer: a memory responder, a queue-based
// run model checked every cycle, and literal expectations for the directed runs.
module tb_conv_result_streamer;
   localparam int AW = 5;
   localparam int RW = 16;
   localparam int CW = 6;

   logic          clk = 1'b0;
   logic          rst, start, m_ready;
   logic [AW-1:0] sizeX, sizeY;
   logic [CW-1:0] memZ_addr;
   logic          memZ_rd;
   logic [RW-1:0] memZ_data, m_data;
   logic          m_valid, m_last, busy, done;
   logic [1:0]    dbg_state;

   conv_result_streamer #(.DATA_WIDTH(8), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .sizeX(sizeX), .sizeY(sizeY),
      .memZ_addr(memZ_addr), .memZ_rd(memZ_rd), .memZ_data(memZ_data),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
      .busy(busy), .done(done), .dbg_state_o(dbg_state)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int rdy_mode = 0;
   logic [RW-1:0] mem [0:63];

   // run model state
   int phase = 0;
   int n_m = 0, next_addr = 0, accepted = 0, t0 = 0, cyc = 0;
   bit full_rate = 0, rst_prev = 0, stall_prev = 0;
   logic [RW-1:0] stall_data;
   logic          stall_last;
   logic [RW-1:0] exp_q[$];
   logic [RW-1:0] got_q[$];
   int first_valid_off, last_off, done_off, rd_seen, valid_seen, busy_seen, done_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_mem(input bit ramp);
      for (int a = 0; a < 64; a++) mem[a] = ramp ? RW'(a + 16) : RW'($urandom);
   endtask

   task automatic run_start(input int x, input int y);
      start = 1'b1;
      sizeX = AW'(x);
      sizeY = AW'(y);
      tick();
      start = 1'b0;
      sizeX = AW'($urandom);
      sizeY = AW'($urandom);
   endtask

   task automatic wait_done(input int budget);
      int k;
      k = 0;
      while (done_cnt == 0 && k < budget) begin
         tick();
         k++;
      end
      checks++;
      if (done_cnt == 0) begin
         errors++;
         $display("FAIL wait_done: actual timeout required done within %0d cycles", budget);
      end
      tick();
   endtask

   // Memory responder: data for a read appears in the cycle after memZ_rd, garbage otherwise.
   initial begin
      bit pend;
      logic [CW-1:0] pend_addr;
      pend = 0;
      pend_addr = '0;
      memZ_data = '0;
      forever begin
         @(negedge clk);
         if (pend) memZ_data = mem[pend_addr];
         else      memZ_data = RW'($urandom);
         pend = memZ_rd;
         pend_addr = memZ_addr;
      end
   end

   initial begin
      int pat;
      pat = 0;
      m_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = (pat % 3 == 0);
            default: m_ready = 1'($urandom_range(0, 1));
         endcase
         pat++;
      end
   end

   // Compare process: outputs checked against the run model every cycle.
   always @(negedge clk) begin
      bit hs;
      cyc++;
      if (rst_prev) begin
         chk("rst_addr", 32'(memZ_addr), 0);
         chk("rst_rd", 32'(memZ_rd), 0);
         chk("rst_valid", 32'(m_valid), 0);
         chk("rst_last", 32'(m_last), 0);
         chk("rst_data", 32'(m_data), 0);
      end
      chk("busy", 32'(busy), 32'(phase == 1));
      chk("done", 32'(done), 32'(phase == 2));
      if (phase != 1) chk("valid_outside_run", 32'(m_valid), 0);
      if (phase == 1 && full_rate) begin
         chk("rd_timing", 32'(memZ_rd), 32'(cyc - t0 >= 1 && cyc - t0 <= n_m));
         chk("valid_timing", 32'(m_valid), 32'(cyc - t0 >= 3 && cyc - t0 <= 2 + n_m));
      end
      if (memZ_rd) begin
         chk("rd_in_run", 32'(phase), 1);
         chk("rd_addr", 32'(memZ_addr), 32'(next_addr));
         next_addr++;
         chk("rd_within_n", 32'(next_addr <= n_m), 1);
         rd_seen++;
      end
      if (stall_prev) begin
         chk("stall_valid", 32'(m_valid), 1);
         chk("stall_data", 32'(m_data), 32'(stall_data));
         chk("stall_last", 32'(m_last), 32'(stall_last));
      end
      if (m_valid) begin
         valid_seen++;
         if (first_valid_off < 0) first_valid_off = cyc - t0;
         if (exp_q.size() == 0) begin
            chk("extra_beat", 32'(m_valid), 0);
         end else begin
            chk("beat_data", 32'(m_data), 32'(exp_q[0]));
            chk("beat_last", 32'(m_last), 32'(exp_q.size() == 1));
         end
      end
      hs = m_valid && m_ready;
      stall_prev = m_valid && !m_ready && !rst;
      stall_data = m_data;
      stall_last = m_last;
      if (hs && exp_q.size() > 0) begin
         got_q.push_back(m_data);
         void'(exp_q.pop_front());
         accepted++;
         if (m_last) last_off = cyc - t0;
      end
      if (phase == 1) chk("outstanding", 32'(next_addr - accepted <= 2), 1);
      if (busy) busy_seen++;
      if (done) begin
         done_cnt++;
         done_off = cyc - t0;
      end
      if (rst) begin
         phase = 0;
         exp_q.delete();
      end else begin
         case (phase)
            0: if (start) begin
               n_m = (sizeX == 0 || sizeY == 0) ? 0 : int'(sizeX) + int'(sizeY) - 1;
               t0 = cyc;
               full_rate = (rdy_mode == 0);
               next_addr = 0;
               accepted = 0;
               exp_q.delete();
               got_q.delete();
               for (int k = 0; k < n_m; k++) exp_q.push_back(mem[k]);
               first_valid_off = -1; last_off = -1; done_off = -1;
               rd_seen = 0; valid_seen = 0; busy_seen = 0; done_cnt = 0;
               phase = (n_m > 0) ? 1 : 2;
            end
            1: if (hs && accepted == n_m) phase = 2;
            default: phase = 0;
         endcase
      end
      rst_prev = rst;
   end

   initial begin
      rst = 1'b1;
      start = 1'b0;
      sizeX = '0;
      sizeY = '0;
      fill_mem(1);
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // 4x3 at full rate: beats 16..21 at T+3..T+8, done at T+9
      rdy_mode = 0;
      run_start(4, 3);
      wait_done(100);
      chk("t1_beats", 32'(got_q.size()), 6);
      for (int k = 0; k < got_q.size(); k++) chk("t1_value", 32'(got_q[k]), 32'(16 + k));
      chk("t1_first_valid", 32'(first_valid_off), 3);
      chk("t1_last", 32'(last_off), 8);
      chk("t1_done", 32'(done_off), 9);
      chk("t1_reads", 32'(rd_seen), 6);

      // same run with ready pattern 1,0,0
      rdy_mode = 1;
      run_start(4, 3);
      wait_done(200);
      chk("t2_beats", 32'(got_q.size()), 6);
      for (int k = 0; k < got_q.size(); k++) chk("t2_value", 32'(got_q[k]), 32'(16 + k));
      chk("t2_done_cnt", 32'(done_cnt), 1);

      // empty run
      rdy_mode = 0;
      run_start(0, 5);
      wait_done(20);
      chk("t3_reads", 32'(rd_seen), 0);
      chk("t3_valid", 32'(valid_seen), 0);
      chk("t3_busy", 32'(busy_seen), 0);
      chk("t3_done", 32'(done_off), 1);

      // largest run
      fill_mem(0);
      run_start(31, 31);
      wait_done(200);
      chk("t4_beats", 32'(got_q.size()), 61);
      chk("t4_reads", 32'(rd_seen), 61);
      chk("t4_last", 32'(last_off), 63);

      // reset at T+5 of a 6-beat run, then a fresh run
      fill_mem(1);
      run_start(4, 3);
      repeat (4) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_partial_beats", 32'(got_q.size()), 3);
      chk("t5_no_done", 32'(done_cnt), 0);
      tick();
      fill_mem(0);
      rdy_mode = 2;
      run_start(6, 6);
      wait_done(400);
      chk("t5_beats", 32'(got_q.size()), 11);
      chk("t5_first_addr_reads", 32'(rd_seen), 11);

      // start pulsed again mid-run
      run_start(5, 4);
      repeat (3) tick();
      run_start(31, 31);
      wait_done(400);
      chk("t6_beats", 32'(got_q.size()), 8);
      repeat (6) tick();
      chk("t6_done_cnt", 32'(done_cnt), 1);

      // randomized runs
      for (int r = 0; r < 24; r++) begin
         int x, y, n;
         x = $urandom_range(0, 31);
         y = $urandom_range(0, 31);
         if ($urandom_range(0, 5) == 0) x = 0;
         n = (x == 0 || y == 0) ? 0 : x + y - 1;
         rdy_mode = $urandom_range(0, 2);
         fill_mem(0);
         run_start(x, y);
         wait_done(600);
         chk("rand_beats", 32'(got_q.size()), 32'(n));
         chk("rand_done_cnt", 32'(done_cnt), 1);
         repeat ($urandom_range(0, 3)) tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/conv_result_streamer.md
CONV_RESULT_STREAMER -- requirements
Module: conv_result_streamer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the conv operand width; result width is 2*DATA_WIDTH.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, the operand size width; the result address is ADDR_WIDTH+1 bits.
REQ-003 SHALL have port clk, input, 1, the single clock; one clock, all logic on the rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port start, input, 1, a run request, normally tied to the conv done pulse.
REQ-006 SHALL have port sizeX, input, ADDR_WIDTH, the X length.
REQ-007 SHALL have port sizeY, input, ADDR_WIDTH, the Y length.
REQ-008 SHALL have port memZ_addr, output, ADDR_WIDTH+1, the result memory read address.
REQ-009 SHALL have port memZ_rd, output, 1, the result memory read enable.
REQ-010 SHALL have port memZ_data, input, 2*DATA_WIDTH, the result memory read data, valid exactly 1 cycle after memZ_rd.
REQ-011 SHALL have port m_data, output, 2*DATA_WIDTH, the stream data.
REQ-012 SHALL have port m_valid, output, 1, the stream valid.
REQ-013 SHALL have port m_ready, input, 1, the stream ready.
REQ-014 SHALL have port m_last, output, 1, marking the final beat of a run.
REQ-015 SHALL have port busy, output, 1, high while a run is in progress.
REQ-016 SHALL have port done, output, 1, a 1-cycle pulse at the end of a run.

Function
REQ-017 SHALL compute result count N = sizeX + sizeY - 1 in ADDR_WIDTH+1 bits, latched at the start cycle; N = 0 if sizeX == 0 or sizeY == 0.
REQ-018 SHALL use FSM states IDLE, RUN and FIN; IDLE->RUN on start when N>0; IDLE->FIN on start when N==0; RUN->FIN on the handshake of the beat with m_last; FIN->IDLE unconditionally after 1 cycle.
REQ-019 SHALL ignore start in RUN and FIN; sizeX and sizeY are don't-care outside the start cycle.
REQ-020 SHALL issue reads in RUN only, with addresses 0..N-1 ascending, one per memZ_rd cycle, with memZ_addr held at its last value when memZ_rd is low.
REQ-021 SHALL keep a 2-entry output buffer and assert memZ_rd only if (buffered + in-flight - pop_this_cycle) < 2 and the number of reads issued is less than N; no read data is ever dropped.
REQ-022 SHALL capture memZ_data into the buffer in the cycle after its memZ_rd; m_valid = buffer non-empty; m_data = head entry.
REQ-023 SHALL hold m_data and m_last stable while m_valid && !m_ready; a beat transfers on m_valid && m_ready.
REQ-024 SHALL raise m_last only on beat index N-1.
REQ-025 SHALL meet this latency for start accepted in cycle T: first memZ_rd in T+1, first m_valid in T+3; with m_ready held high, 1 beat/cycle, last beat in T+2+N.
REQ-026 SHALL raise busy from the cycle after start through the cycle of the last handshake; done pulses in the FIN cycle; busy and done are never both high.
REQ-027 SHALL never assert m_valid outside RUN.

Reset
REQ-028 SHALL, on rst at any cycle including mid-run, go next cycle to IDLE with memZ_addr=0, memZ_rd=0, m_valid=0, m_last=0, m_data=0, busy=0, done=0, buffer emptied and counters cleared; in-flight read data is discarded.
REQ-029 SHALL give rst priority over start in the same cycle.

Verification
REQ-030 SHALL cover: sizeX=4, sizeY=3, memZ[a]=a+16, m_ready=1, start at T -> 6 beats of data 16..21 in T+3..T+8, m_last at T+8, done at T+9.
REQ-031 SHALL cover: the same run with m_ready toggling 1,0,0,1,... -> the same 6 values in order, none lost or duplicated, m_data stable while stalled, at most 2 reads outstanding beyond accepted beats.
REQ-032 SHALL cover: sizeX=0, sizeY=5, start -> no memZ_rd, no m_valid, done 1 cycle after start, busy never high.
REQ-033 SHALL cover: sizeX=31, sizeY=31 -> 61 beats at addresses 0..60, m_last only on the 61st.
REQ-034 SHALL cover: rst asserted at T+5 of a 6-beat run -> IDLE with all outputs 0 at T+6; a new start then produces a complete run from address 0.
REQ-035 SHALL cover: start pulsed again mid-run -> ignored, run completes unchanged, only one done.
